// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the ME-stage data memory responder.
// Holds the flag encodings, FSM states, byte-enable constants and lane helpers.
package mem_pkg;

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_SB   = 2'b01;
    localparam logic [1:0] ST_SH   = 2'b10;
    localparam logic [1:0] ST_SW   = 2'b11;

    localparam logic [2:0] LD_NONE = 3'b000;
    localparam logic [2:0] LD_LB   = 3'b001;
    localparam logic [2:0] LD_LBU  = 3'b010;
    localparam logic [2:0] LD_LH   = 3'b011;
    localparam logic [2:0] LD_LHU  = 3'b100;
    localparam logic [2:0] LD_LW   = 3'b101;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_ALL     = 4'b1111;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;

    localparam int LANE_BITS = 8;
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } state_e;

    // Encodings 110 and 111 are reserved and behave as "no load".
    function automatic logic isLoadFlag(input logic [2:0] flag);
        return (flag >= LD_LB) && (flag <= LD_LW);
    endfunction

    function automatic logic [3:0] storeByteEnables(input logic [1:0] flag, input logic [1:0] lane);
        logic [3:0] be;
        case (flag)
            ST_SB:   be = 4'b0001 << lane;
            ST_SH:   be = lane[1] ? BE_HI_HALF : BE_LO_HALF;
            ST_SW:   be = BE_ALL;
            default: be = BE_NONE;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] replicateStore(input logic [1:0] flag, input logic [31:0] data);
        logic [31:0] rep;
        case (flag)
            ST_SB:   rep = {NUM_LANES{data[LANE_BITS-1:0]}};
            ST_SH:   rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: picks the addressed byte or half out of an SRAM word and
// sign- or zero-extends it according to the load flag.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  flag_i,
    input  logic [1:0]  lane_i,
    output logic [31:0] data_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = word_i[{lane_i, 3'b000} +: 8];
        halfSel = lane_i[1] ? word_i[31:16] : word_i[15:0];
        case (flag_i)
            LD_LB:   data_o = {{24{byteSel[7]}}, byteSel};
            LD_LBU:  data_o = {24'h000000, byteSel};
            LD_LH:   data_o = {{16{halfSel[15]}}, halfSel};
            LD_LHU:  data_o = {16'h0000, halfSel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: ME-stage data memory port. Stores retire in the request
// cycle; loads stall the pipeline for LAT+1 cycles and return in RESP.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int AW  = 10,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   ram_addr,
    input  logic [31:0]   write_ram_data,
    input  logic [1:0]    write_ram_flag,
    input  logic [2:0]    read_ram_flag,
    output logic [31:0]   ram_out,
    output logic          busy,
    output logic          access_err,
    output logic          sram_en,
    output logic          sram_we,
    output logic [3:0]    sram_be,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);

    // LAT is limited to 1..4, so the wait counter never needs more than two bits.
    localparam logic [1:0] LAT_M1 = 2'(LAT - 1);

    state_e      state_q;
    logic [1:0]  count_q;
    logic [2:0]  loadFlag_q;
    logic [1:0]  lane_q;
    logic [31:0] ramOut_q;

    logic        storeReq;
    logic        loadReq;
    logic        halfAcc;
    logic        wordAcc;
    logic        misaligned;
    logic        reqErr;
    logic        inIdle;
    logic        doStore;
    logic        doLoad;
    logic [31:0] loadExt;
    logic        unusedAddrBits;

    assign unusedAddrBits = ^ram_addr[31:AW+2];

    always_comb begin
        storeReq   = (write_ram_flag != ST_NONE);
        loadReq    = isLoadFlag(read_ram_flag);
        halfAcc    = (write_ram_flag == ST_SH) || (read_ram_flag == LD_LH) || (read_ram_flag == LD_LHU);
        wordAcc    = (write_ram_flag == ST_SW) || (read_ram_flag == LD_LW);
        misaligned = (halfAcc && ram_addr[0]) || (wordAcc && (ram_addr[1:0] != 2'b00));
        reqErr     = misaligned || (storeReq && loadReq);
        inIdle     = rst && (state_q == S_IDLE);
        doStore    = inIdle && storeReq && !reqErr;
        doLoad     = inIdle && loadReq && !reqErr;
    end

    // Every SRAM-facing output is gated by reset so nothing leaks while rst is low.
    always_comb begin
        access_err = inIdle && reqErr;
        busy       = doLoad || (rst && (state_q == S_WAIT));
        sram_en    = doStore || doLoad;
        sram_we    = doStore;
        sram_be    = BE_NONE;
        if (doStore) begin
            sram_be = storeByteEnables(write_ram_flag, ram_addr[1:0]);
        end else if (doLoad) begin
            sram_be = BE_ALL;
        end
        sram_addr  = rst ? ram_addr[AW+1:2] : '0;
        sram_wdata = rst ? replicateStore(write_ram_flag, write_ram_data) : '0;
    end

    load_extend u_extend (
        .word_i (sram_rdata),
        .flag_i (loadFlag_q),
        .lane_i (lane_q),
        .data_o (loadExt)
    );

    // Load FSM: the latched flag and lane drive extension, never the live inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            count_q    <= 2'd0;
            loadFlag_q <= LD_NONE;
            lane_q     <= 2'd0;
            ramOut_q   <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (doLoad) begin
                        state_q    <= S_WAIT;
                        count_q    <= LAT_M1;
                        loadFlag_q <= read_ram_flag;
                        lane_q     <= ram_addr[1:0];
                    end
                end
                S_WAIT: begin
                    if (count_q == 2'd0) begin
                        ramOut_q <= loadExt;
                        state_q  <= S_RESP;
                    end else begin
                        count_q <= count_q - 2'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ram_out = ramOut_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: three responders (LAT 1, 2, 4) each with its own SRAM
// model, checked against a byte-array memory model held in the bench.
module tb_dmem_responder;

    localparam int AW    = 10;
    localparam int NDUT  = 3;
    localparam int NBYTE = 4 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstN      [NDUT];
    logic [31:0]   ramAddr   [NDUT];
    logic [31:0]   wrData    [NDUT];
    logic [1:0]    wrFlag    [NDUT];
    logic [2:0]    rdFlag    [NDUT];
    logic [31:0]   ramOut    [NDUT];
    logic          busy      [NDUT];
    logic          accErr    [NDUT];
    logic          sramEn    [NDUT];
    logic          sramWe    [NDUT];
    logic [3:0]    sramBe    [NDUT];
    logic [AW-1:0] sramAddr  [NDUT];
    logic [31:0]   sramWdata [NDUT];
    logic [31:0]   sramRdata [NDUT];

    logic [7:0]    refMem       [NDUT][NBYTE];
    logic [31:0]   lastOut      [NDUT];
    int            lastIssueCyc [NDUT];
    int            lastRespCyc  [NDUT];

    int testsRun    = 0;
    int testsFailed = 0;
    int cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : gSlot
        localparam int LatG = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        logic [31:0] mem  [2**AW];
        logic [31:0] pipe [LatG];

        dmem_responder #(.AW(AW), .LAT(LatG)) dut (
            .clk            (clk),
            .rst            (rstN[g]),
            .ram_addr       (ramAddr[g]),
            .write_ram_data (wrData[g]),
            .write_ram_flag (wrFlag[g]),
            .read_ram_flag  (rdFlag[g]),
            .ram_out        (ramOut[g]),
            .busy           (busy[g]),
            .access_err     (accErr[g]),
            .sram_en        (sramEn[g]),
            .sram_we        (sramWe[g]),
            .sram_be        (sramBe[g]),
            .sram_addr      (sramAddr[g]),
            .sram_wdata     (sramWdata[g]),
            .sram_rdata     (sramRdata[g])
        );

        // Read data is only valid exactly LatG cycles after the issue cycle.
        always_ff @(posedge clk) begin
            if (sramEn[g] && sramWe[g]) begin
                for (int b = 0; b < 4; b++) begin
                    if (sramBe[g][b]) mem[sramAddr[g]][8*b +: 8] <= sramWdata[g][8*b +: 8];
                end
            end
            pipe[0] <= (sramEn[g] && !sramWe[g]) ? mem[sramAddr[g]] : 32'hBAD0BAD0;
            for (int k = 1; k < LatG; k++) pipe[k] <= pipe[k-1];
        end

        assign sramRdata[g] = pipe[LatG-1];
    end

    function automatic int latOf(input int idx);
        return (idx == 0) ? 1 : (idx == 1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] modelLoad(input int idx, input logic [31:0] addr, input logic [2:0] flag);
        int a;
        logic [7:0]  b;
        logic [15:0] h;
        a = int'(addr[AW+1:0]);
        case (flag)
            3'd1: begin b = refMem[idx][a]; return {{24{b[7]}}, b}; end
            3'd2: begin b = refMem[idx][a]; return {24'h0, b}; end
            3'd3: begin h = {refMem[idx][a+1], refMem[idx][a]}; return {{16{h[15]}}, h}; end
            3'd4: begin h = {refMem[idx][a+1], refMem[idx][a]}; return {16'h0, h}; end
            3'd5: return {refMem[idx][a+3], refMem[idx][a+2], refMem[idx][a+1], refMem[idx][a]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic doStore(input int idx, input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] flag, input string tag);
        int nBytes;
        int lane;
        int a;
        logic expErr;
        logic [3:0] expBe;
        logic wdOk;
        nBytes = (flag == 2'd1) ? 1 : (flag == 2'd2) ? 2 : 4;
        lane   = int'(addr[1:0]);
        a      = int'(addr[AW+1:0]);
        expErr = (nBytes == 2 && addr[0]) || (nBytes == 4 && addr[1:0] != 2'b00);
        expBe  = 4'b0000;
        if (!expErr) for (int i = 0; i < nBytes; i++) expBe[lane+i] = 1'b1;
        @(negedge clk);
        ramAddr[idx] = addr;
        wrData[idx]  = data;
        wrFlag[idx]  = flag;
        rdFlag[idx]  = 3'd0;
        #1;
        wdOk = 1'b1;
        if (!expErr) begin
            for (int i = 0; i < nBytes; i++) begin
                if (sramWdata[idx][8*(lane+i) +: 8] !== data[8*i +: 8]) wdOk = 1'b0;
            end
        end
        testsRun++;
        if (accErr[idx] !== expErr || sramEn[idx] !== !expErr || sramWe[idx] !== !expErr ||
            sramBe[idx] !== expBe || busy[idx] !== 1'b0 || wdOk !== 1'b1 ||
            (!expErr && sramAddr[idx] !== addr[AW+1:2])) begin
            testsFailed++;
            $display("[TB] FAIL %s dut%0d: got err=%b en=%b we=%b be=%b addr=%h busy=%b wdata=%h, expected err=%b en=%b be=%b addr=%h busy=0",
                     tag, idx, accErr[idx], sramEn[idx], sramWe[idx], sramBe[idx], sramAddr[idx], busy[idx],
                     sramWdata[idx], expErr, !expErr, expBe, addr[AW+1:2]);
        end
        if (!expErr) for (int i = 0; i < nBytes; i++) refMem[idx][a+i] = data[8*i +: 8];
        @(posedge clk);
        #1;
        wrFlag[idx] = 2'd0;
    endtask

    task automatic doLoad(input int idx, input logic [31:0] addr, input logic [2:0] flag,
                          input string tag, output logic [31:0] got);
        logic isLoad;
        logic expErr;
        logic [31:0] expVal;
        int cycles;
        isLoad = (flag >= 3'd1) && (flag <= 3'd5);
        expErr = isLoad && ((((flag == 3'd3) || (flag == 3'd4)) && addr[0]) ||
                            ((flag == 3'd5) && (addr[1:0] != 2'b00)));
        expVal = (isLoad && !expErr) ? modelLoad(idx, addr, flag) : lastOut[idx];
        @(negedge clk);
        ramAddr[idx] = addr;
        rdFlag[idx]  = flag;
        wrFlag[idx]  = 2'd0;
        #1;
        lastIssueCyc[idx] = cyc;
        testsRun++;
        if (isLoad && !expErr) begin
            if (accErr[idx] !== 1'b0 || busy[idx] !== 1'b1 || sramEn[idx] !== 1'b1 || sramWe[idx] !== 1'b0 ||
                sramBe[idx] !== 4'hF || sramAddr[idx] !== addr[AW+1:2] || ramOut[idx] !== lastOut[idx]) begin
                testsFailed++;
                $display("[TB] FAIL %s_issue dut%0d: got err=%b busy=%b en=%b we=%b be=%b addr=%h out=%h, expected 0 1 1 0 1111 %h out=%h",
                         tag, idx, accErr[idx], busy[idx], sramEn[idx], sramWe[idx], sramBe[idx], sramAddr[idx],
                         ramOut[idx], addr[AW+1:2], lastOut[idx]);
            end
        end else begin
            if (accErr[idx] !== expErr || busy[idx] !== 1'b0 || sramEn[idx] !== 1'b0 || sramWe[idx] !== 1'b0 ||
                sramBe[idx] !== 4'h0 || ramOut[idx] !== lastOut[idx]) begin
                testsFailed++;
                $display("[TB] FAIL %s_noissue dut%0d: got err=%b busy=%b en=%b be=%b out=%h, expected err=%b busy=0 en=0 be=0000 out=%h",
                         tag, idx, accErr[idx], busy[idx], sramEn[idx], sramBe[idx], ramOut[idx], expErr, lastOut[idx]);
            end
        end
        if (isLoad && !expErr) begin
            cycles = 1;
            while (cycles < 20) begin
                @(negedge clk);
                #1;
                if (busy[idx] !== 1'b1) break;
                cycles++;
            end
            lastRespCyc[idx] = cyc;
            testsRun++;
            if (cycles != latOf(idx) + 1) begin
                testsFailed++;
                $display("[TB] FAIL %s_latency dut%0d: busy cycles got %0d, expected %0d", tag, idx, cycles, latOf(idx) + 1);
            end
            testsRun++;
            if (ramOut[idx] !== expVal || sramEn[idx] !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL %s_data dut%0d: got out=%h en=%b, expected out=%h en=0", tag, idx, ramOut[idx], sramEn[idx], expVal);
            end
            lastOut[idx] = expVal;
        end
        got = ramOut[idx];
        @(posedge clk);
        #1;
        rdFlag[idx] = 3'd0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NDUT; i++) begin
            rstN[i]    = 1'b0;
            ramAddr[i] = 32'h0000_0011;
            wrData[i]  = 32'hFFFF_FFFF;
            wrFlag[i]  = 2'd3;
            rdFlag[i]  = 3'd5;
            lastOut[i] = 32'h0;
        end
        #2;
        for (int i = 0; i < NDUT; i++) begin
            testsRun++;
            if (busy[i] !== 1'b0 || ramOut[i] !== 32'h0 || accErr[i] !== 1'b0 || sramEn[i] !== 1'b0 ||
                sramWe[i] !== 1'b0 || sramBe[i] !== 4'h0 || sramAddr[i] !== '0 || sramWdata[i] !== 32'h0) begin
                testsFailed++;
                $display("[TB] FAIL reset dut%0d: got busy=%b out=%h err=%b en=%b we=%b be=%b addr=%h wdata=%h, expected all zero",
                         i, busy[i], ramOut[i], accErr[i], sramEn[i], sramWe[i], sramBe[i], sramAddr[i], sramWdata[i]);
            end
        end
        for (int i = 0; i < NDUT; i++) begin
            wrFlag[i] = 2'd0;
            rdFlag[i] = 3'd0;
        end
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) rstN[i] = 1'b1;
    endtask

    task automatic test_word_store_load();
        logic [31:0] got;
        doStore(0, 32'h10, 32'hDEADBEEF, 2'd3, "sw_word");
        doLoad(0, 32'h10, 3'd5, "lw_word", got);
        testsRun++;
        if (got !== 32'hDEADBEEF) begin
            testsFailed++;
            $display("[TB] FAIL lw_word_const: got %h, expected deadbeef", got);
        end
    endtask

    task automatic test_subword();
        logic [31:0] got;
        doStore(0, 32'h13, 32'h0000_0080, 2'd1, "sb_lane3");
        doLoad(0, 32'h13, 3'd1, "lb", got);
        testsRun++;
        if (got !== 32'hFFFFFF80) begin
            testsFailed++;
            $display("[TB] FAIL lb_const: got %h, expected ffffff80", got);
        end
        doLoad(0, 32'h13, 3'd2, "lbu", got);
        doStore(0, 32'h12, 32'h0000_8001, 2'd2, "sh_hi");
        doLoad(0, 32'h12, 3'd3, "lh", got);
        testsRun++;
        if (got !== 32'hFFFF8001) begin
            testsFailed++;
            $display("[TB] FAIL lh_const: got %h, expected ffff8001", got);
        end
        doLoad(0, 32'h12, 3'd4, "lhu", got);
    endtask

    task automatic test_errors();
        logic [31:0] got;
        doStore(0, 32'h30, 32'h0BADCAFE, 2'd3, "sw_pre_err");
        doLoad(0, 32'h11, 3'd5, "lw_misaligned", got);
        doLoad(0, 32'h31, 3'd3, "lh_misaligned", got);
        doStore(0, 32'h32, 32'h5555_5555, 2'd3, "sw_misaligned");
        @(negedge clk);
        ramAddr[0] = 32'h30;
        wrData[0]  = 32'h1111_1111;
        wrFlag[0]  = 2'd3;
        rdFlag[0]  = 3'd5;
        #1;
        testsRun++;
        if (accErr[0] !== 1'b1 || sramEn[0] !== 1'b0 || sramWe[0] !== 1'b0 || busy[0] !== 1'b0 || sramBe[0] !== 4'h0) begin
            testsFailed++;
            $display("[TB] FAIL conflict: got err=%b en=%b we=%b busy=%b be=%b, expected 1 0 0 0 0000",
                     accErr[0], sramEn[0], sramWe[0], busy[0], sramBe[0]);
        end
        @(posedge clk);
        #1;
        wrFlag[0] = 2'd0;
        rdFlag[0] = 3'd0;
        doLoad(0, 32'h30, 3'd5, "lw_after_conflict", got);
    endtask

    task automatic test_latency_sweep();
        logic [31:0] got;
        for (int i = 0; i < NDUT; i++) begin
            doStore(i, 32'h50, 32'h0F1E2D3C + i, 2'd3, "sw_lat");
            doLoad(i, 32'h50, 3'd5, "lw_lat", got);
            doLoad(i, 32'h52, 3'd3, "lh_lat", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        int respFirst;
        doStore(1, 32'h60, 32'hAAAA_0001, 2'd3, "sw_b2b_a");
        doStore(1, 32'h64, 32'hBBBB_0002, 2'd3, "sw_b2b_b");
        doLoad(1, 32'h60, 3'd5, "lw_b2b_a", got);
        respFirst = lastRespCyc[1];
        doLoad(1, 32'h64, 3'd5, "lw_b2b_b", got);
        testsRun++;
        if (lastIssueCyc[1] - respFirst != 1) begin
            testsFailed++;
            $display("[TB] FAIL b2b_gap: got issue-resp gap %0d, expected 1", lastIssueCyc[1] - respFirst);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] got;
        logic noResp;
        doStore(2, 32'h40, 32'h12345678, 2'd3, "sw_rst_a");
        doLoad(2, 32'h40, 3'd5, "lw_rst_a", got);
        doStore(2, 32'h44, 32'hCAFEF00D, 2'd3, "sw_rst_b");
        @(negedge clk);
        ramAddr[2] = 32'h44;
        rdFlag[2]  = 3'd5;
        @(negedge clk);
        @(negedge clk);
        #1;
        testsRun++;
        if (busy[2] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL midload_busy: got busy=%b, expected 1", busy[2]);
        end
        rstN[2] = 1'b0;
        #1;
        rdFlag[2] = 3'd0;
        testsRun++;
        if (busy[2] !== 1'b0 || ramOut[2] !== 32'h0 || sramEn[2] !== 1'b0 || sramBe[2] !== 4'h0 ||
            sramAddr[2] !== '0 || sramWdata[2] !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL midload_reset: got busy=%b out=%h en=%b be=%b addr=%h wdata=%h, expected all zero",
                     busy[2], ramOut[2], sramEn[2], sramBe[2], sramAddr[2], sramWdata[2]);
        end
        lastOut[2] = 32'h0;
        @(negedge clk);
        rstN[2] = 1'b1;
        noResp = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            if (busy[2] !== 1'b0 || ramOut[2] !== 32'h0) noResp = 1'b0;
        end
        testsRun++;
        if (noResp !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL midload_no_resp: got busy=%b out=%h after reset, expected 0 and 00000000", busy[2], ramOut[2]);
        end
        doLoad(2, 32'h44, 3'd5, "lw_after_reset", got);
    endtask

    task automatic test_address_wrap();
        logic [31:0] got;
        doStore(0, 32'h0, 32'hA5A55A5A, 2'd3, "sw_zero");
        doLoad(0, 32'h1000, 3'd5, "lw_wrap", got);
        testsRun++;
        if (got !== 32'hA5A55A5A) begin
            testsFailed++;
            $display("[TB] FAIL wrap_const: got %h, expected a5a55a5a", got);
        end
    endtask

    task automatic test_random();
        logic [31:0] got;
        logic [31:0] addr;
        logic [1:0]  sf;
        logic [2:0]  lf;
        int kind;
        int nBytes;
        for (int i = 0; i < NDUT; i++) begin
            for (int w = 0; w < 16; w++) doStore(i, 32'h200 + 32'(4 * w), $urandom, 2'd3, "rand_fill");
            for (int n = 0; n < 30; n++) begin
                kind = $urandom_range(0, 9);
                addr = 32'h200 + 32'($urandom_range(0, 63));
                addr[31:12] = 20'($urandom);
                if (kind < 4) begin
                    sf = 2'($urandom_range(1, 3));
                    nBytes = (sf == 2'd1) ? 1 : (sf == 2'd2) ? 2 : 4;
                    if ($urandom_range(0, 4) != 0) addr = addr & ~32'(nBytes - 1);
                    doStore(i, addr, $urandom, sf, "rand_store");
                end else if (kind < 9) begin
                    lf = 3'($urandom_range(1, 5));
                    nBytes = (lf <= 3'd2) ? 1 : (lf <= 3'd4) ? 2 : 4;
                    if ($urandom_range(0, 4) != 0) addr = addr & ~32'(nBytes - 1);
                    doLoad(i, addr, lf, "rand_load", got);
                end else begin
                    lf = ($urandom_range(0, 1) == 0) ? 3'd6 : 3'd7;
                    doLoad(i, addr, lf, "rand_noop", got);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_word_store_load();
        test_subword();
        test_errors();
        test_latency_sweep();
        test_back_to_back();
        test_reset_mid_load();
        test_address_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
